// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with optional skid register, flush, occupancy
// and a saturating back-pressure counter.
module pipe_stage_reg #(
   parameter int WIDTH = 32,
   parameter int SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             mvld_q, mvld_d;
   logic             svld_q, svld_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [1:0]       occ_q, occ_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             in_xfer, out_xfer;

   // Skid variant breaks the out_ready -> in_ready path; plain variant keeps it.
   generate
      if (SKID != 0) begin : g_skid
         assign in_ready = !svld_q;
      end else begin : g_noskid
         assign in_ready = !mvld_q || out_ready;
      end
   endgenerate

   always_comb begin
      in_xfer  = in_valid && in_ready;
      out_xfer = mvld_q && out_ready;
      mvld_d   = mvld_q;
      svld_d   = svld_q;
      main_d   = main_q;
      skid_d   = skid_q;
      if (!mvld_q) begin
         if (in_xfer) begin
            mvld_d = 1'b1;
            main_d = in_data;
         end
      end else if (!svld_q) begin
         if (in_xfer && out_xfer) begin
            main_d = in_data;
         end else if (in_xfer) begin
            // Only reachable with SKID=1: without a skid, in_xfer here implies out_xfer.
            svld_d = 1'b1;
            skid_d = in_data;
         end else if (out_xfer) begin
            mvld_d = 1'b0;
         end
      end else if (out_xfer) begin
         main_d = skid_q;
         svld_d = 1'b0;
      end
      // Flush drops everything held; data registers keep their old contents.
      if (flush) begin
         mvld_d = 1'b0;
         svld_d = 1'b0;
         main_d = main_q;
         skid_d = skid_q;
      end
      occ_d   = {1'b0, mvld_d} + {1'b0, svld_d};
      stall_d = stall_q;
      if (mvld_q && !out_ready && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mvld_q  <= 1'b0;
         svld_q  <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
         occ_q   <= 2'd0;
         stall_q <= '0;
      end else begin
         mvld_q  <= mvld_d;
         svld_q  <= svld_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         occ_q   <= occ_d;
         stall_q <= stall_d;
      end
   end

   assign out_valid = mvld_q;
   assign out_data  = main_q;
   assign occupancy = occ_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: DUT a is the skid variant (32b, 16b counter), DUT b the
// combinational-ready variant (8b, 4b counter).
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_flush, a_iv, a_ir, a_ov, a_or;
   logic [31:0] a_id, a_od;
   logic [1:0]  a_occ;
   logic [15:0] a_stall;

   logic        b_rst, b_flush, b_iv, b_ir, b_ov, b_or;
   logic [7:0]  b_id, b_od;
   logic [1:0]  b_occ;
   logic [3:0]  b_stall;

   pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
      .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
      .occupancy(a_occ), .stall_cnt(a_stall));

   pipe_stage_reg #(.WIDTH(8), .SKID(0), .CNT_W(4)) u_b (
      .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
      .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
      .occupancy(b_occ), .stall_cnt(b_stall));

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] a_q[$];
   logic [7:0]  b_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitors: pop expected beat on every output transfer.
   always @(negedge clk) begin
      if (!a_rst && a_ov && a_or) begin
         if (a_q.size() == 0) chk("a_unexpected_beat", a_od, 32'hxxxx_xxxx);
         else chk("a_out_data", a_od, a_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!b_rst) chk("b_occ_le1", {31'd0, (b_occ <= 2'd1)}, 32'd1);
      if (!b_rst && b_ov && b_or) begin
         if (b_q.size() == 0) chk("b_unexpected_beat", {24'd0, b_od}, 32'hxxxx_xxxx);
         else chk("b_out_data", {24'd0, b_od}, {24'd0, b_q.pop_front()});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wait_acc();
      logic acc;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         acc = a_ir;
         tick();
         if (acc) return;
      end
      chk("a_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic b_wait_acc();
      logic acc;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         acc = b_ir;
         tick();
         if (acc) return;
      end
      chk("b_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic a_send(input logic [31:0] d);
      a_iv = 1'b1; a_id = d; a_q.push_back(d);
      a_wait_acc();
   endtask

   task automatic b_send(input logic [7:0] d);
      b_iv = 1'b1; b_id = d; b_q.push_back(d);
      b_wait_acc();
   endtask

   initial begin
      a_rst = 1; a_flush = 0; a_iv = 0; a_id = '0; a_or = 0;
      b_rst = 1; b_flush = 0; b_iv = 0; b_id = '0; b_or = 0;
      tick(); tick();
      chk("a_rst_ov", {31'd0, a_ov}, 32'd0);
      chk("a_rst_occ", {30'd0, a_occ}, 32'd0);
      chk("a_rst_stall", {16'd0, a_stall}, 32'd0);
      chk("a_rst_data", a_od, 32'd0);
      chk("b_rst_ov", {31'd0, b_ov}, 32'd0);
      chk("b_rst_stall", {28'd0, b_stall}, 32'd0);
      a_rst = 0; b_rst = 0;
      tick();
      chk("a_rst_ir", {31'd0, a_ir}, 32'd1);
      chk("b_rst_ir", {31'd0, b_ir}, 32'd1);

      // Back-to-back stream with no back-pressure.
      a_or = 1;
      a_send(32'h11);
      chk("a_stream_first", a_od, 32'h11);
      chk("a_stream_ir1", {31'd0, a_ir}, 32'd1);
      a_send(32'h22);
      chk("a_stream_ir2", {31'd0, a_ir}, 32'd1);
      a_send(32'h33);
      a_iv = 0;
      tick(); tick();
      chk("a_stream_stall", {16'd0, a_stall}, 32'd0);
      chk("a_stream_empty", {30'd0, a_occ}, 32'd0);

      // Fill both registers under back-pressure, third beat must wait.
      a_or = 0;
      a_send(32'hA);
      a_send(32'hB);
      a_iv = 1; a_id = 32'hC; a_q.push_back(32'hC);
      tick(); tick();
      chk("a_full_occ", {30'd0, a_occ}, 32'd2);
      chk("a_full_ir", {31'd0, a_ir}, 32'd0);
      chk("a_full_data", a_od, 32'hA);
      chk("a_full_stall", {16'd0, a_stall}, 32'd3);
      a_or = 1;
      a_wait_acc();
      a_iv = 0;
      tick(); tick(); tick();
      chk("a_drain_occ", {30'd0, a_occ}, 32'd0);
      chk("a_drain_ov", {31'd0, a_ov}, 32'd0);
      chk("a_drain_stall", {16'd0, a_stall}, 32'd3);

      // Flush with two beats held and a new beat offered.
      a_or = 0;
      a_send(32'h5);
      a_send(32'h6);
      chk("a_pre_flush_occ", {30'd0, a_occ}, 32'd2);
      a_iv = 1; a_id = 32'h7; a_flush = 1;
      tick();
      a_flush = 0; a_iv = 0;
      a_q.delete();
      chk("a_flush_ov", {31'd0, a_ov}, 32'd0);
      chk("a_flush_occ", {30'd0, a_occ}, 32'd0);
      chk("a_flush_stall", {16'd0, a_stall}, 32'd5);
      chk("a_flush_ir", {31'd0, a_ir}, 32'd1);
      a_or = 1;
      tick(); tick();
      a_send(32'h99);
      a_iv = 0;
      tick(); tick();

      // Combinational ready in the no-skid stage.
      b_or = 0;
      b_send(8'h3C);
      b_iv = 0;
      chk("b_held_ir", {31'd0, b_ir}, 32'd0);
      b_or = 1;
      #1;
      chk("b_comb_ir", {31'd0, b_ir}, 32'd1);
      b_send(8'h5A);
      b_iv = 0;
      chk("b_replace_data", {24'd0, b_od}, 32'h5A);
      chk("b_replace_occ", {30'd0, b_occ}, 32'd1);
      chk("b_replace_stall", {28'd0, b_stall}, 32'd0);
      tick(); tick();

      // Saturation then reset mid-stall.
      b_or = 0;
      b_send(8'h77);
      b_iv = 0;
      for (int i = 0; i < 20; i++) tick();
      chk("b_sat_stall", {28'd0, b_stall}, 32'hF);
      chk("b_sat_data", {24'd0, b_od}, 32'h77);
      b_rst = 1;
      tick();
      chk("b_rst2_ov", {31'd0, b_ov}, 32'd0);
      chk("b_rst2_stall", {28'd0, b_stall}, 32'd0);
      b_q.delete();
      b_rst = 0;
      tick();

      chk("a_queue_drained", a_q.size(), 32'd0);
      chk("b_queue_drained", b_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits (legal 1..1024).
REQ-002 SHALL have parameter SKID, default 1: 1 = two-entry stage with registered in_ready; 0 = one-entry stage with combinational in_ready.
REQ-003 SHALL have parameter CNT_W, default 16: stall counter width (legal 4..32).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous to clk, active-high.
REQ-006 SHALL have port flush  input  1: discard all held beats.
REQ-007 SHALL have port in_valid  input  1: upstream beat present.
REQ-008 SHALL have port in_ready  output  1: stage can accept a beat.
REQ-009 SHALL have port in_data  input  WIDTH: upstream payload.
REQ-010 SHALL have port out_valid  output  1: downstream beat present.
REQ-011 SHALL have port out_ready  input  1: downstream accepts.
REQ-012 SHALL have port out_data  output  WIDTH: downstream payload, driven directly from the main register.
REQ-013 SHALL have port occupancy  output  2: number of held beats (0..2).
REQ-014 SHALL have port stall_cnt  output  CNT_W: count of back-pressured cycles.

Function
REQ-015 SHALL define an input transfer as in_valid && in_ready and an output transfer as out_valid && out_ready in the same cycle.
REQ-016 SHALL hold beats in a main register (drives out_*) and, when SKID=1, a skid register; states EMPTY (0 beats), FULL (main valid), SKID (main+skid valid; SKID=1 only).
REQ-017 SHALL present an accepted beat on out_* in the cycle after its input transfer (1-cycle latency) when the stage was EMPTY or transferring out.
REQ-018 EMPTY: input transfer -> FULL, main <= in_data; else stay EMPTY.
REQ-019 FULL: in+out transfer -> FULL, main <= in_data; in only -> SKID, skid <= in_data (SKID=1); out only -> EMPTY; neither -> FULL, main unchanged.
REQ-020 SKID: in_ready=0; output transfer -> FULL, main <= skid; else stay SKID with both registers unchanged.
REQ-021 SKID=1: in_ready SHALL equal !skid_valid (register output only, no combinational path from out_ready).
REQ-022 SKID=0: in_ready SHALL equal !out_valid || out_ready; state SKID never reached; occupancy never exceeds 1.
REQ-023 SHALL preserve beat order with no loss and no duplication in absence of flush.
REQ-024 flush=1: next state EMPTY (both valid bits 0) regardless of other inputs; any input transfer in that cycle is discarded; out_valid may still be 1 during the flush cycle and an output transfer in that cycle counts as delivered.
REQ-025 in_ready SHALL NOT depend on flush.
REQ-026 occupancy SHALL equal main_valid + skid_valid, registered.
REQ-027 stall_cnt SHALL increment by 1 each cycle with out_valid && !out_ready, saturating at all-ones; flush SHALL NOT clear it.
REQ-028 out_data SHALL remain stable while out_valid && !out_ready (no flush).
REQ-029 Data registers SHALL load only on their respective transfers; they are not cleared by flush.

Reset
REQ-030 With rst=1 at a clk edge: state EMPTY, out_valid=0, occupancy=0, stall_cnt=0, main and skid data = 0; next cycle in_ready=1.
REQ-031 rst SHALL override flush and all handshakes; beats held or presented mid-operation are dropped.
REQ-032 Outputs SHALL not change between clk edges except in_ready when SKID=0.

Verification
REQ-033 SKID=1, out_ready=1, stream 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on cycles 1,2,3, in_ready=1 throughout, stall_cnt=0.
REQ-034 SKID=1, out_ready=0, send 0xA,0xB,0xC -> 0xA and 0xB held, occupancy=2, in_ready=0, 0xC not accepted; raise out_ready -> 0xA,0xB,0xC delivered in order; stall_cnt counts stalled cycles.
REQ-035 SKID=0, out_ready=0 with one beat held -> in_ready=0; same cycle out_ready=1 -> in_ready=1 combinationally, replacement beat accepted.
REQ-036 Occupancy 2, flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, new beat discarded, stall_cnt retained.
REQ-037 CNT_W=4, out_ready=0 for 20 cycles with beat held -> stall_cnt saturates at 0xF; rst mid-stall -> out_valid=0, stall_cnt=0 next cycle.
